// File: rtl/rom_load_sequencer.sv
// rom_load_sequencer: copies NSEG boot images from SPI flash into RAM, then
// hands the RAM port to the core and releases core reset.
// Optional build macro ROM_CHECKSUM_EN adds a 16-bit running sum of loaded bytes;
// without it the checksum output is tied to zero.
module rom_load_sequencer #(
  parameter logic [23:0] FLASH_BASE = 24'h080000,
  parameter int          NSEG       = 3,
  parameter logic [16:0] SEG_LEN    = 17'h04000,
  parameter logic [67:0] SEG_RAM    = {17'h00000, 17'h14000, 17'h10000, 17'h0C000},
  parameter logic [7:0]  SETTLE     = 8'hFF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        reload,
  output logic        flash_valid,
  input  logic        flash_ready,
  output logic [23:0] flash_addr,
  input  logic [7:0]  flash_rdata,
  input  logic [16:0] core_addr,
  input  logic        core_we,
  input  logic [7:0]  core_din,
  output logic [16:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  output logic        load_done,
  output logic        core_reset,
  output logic [1:0]  seg_idx,
  output logic [15:0] checksum
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_LAST   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [1:0]  LAST_SEG = 2'(NSEG - 1);
  localparam logic [16:0] LAST_OFF = SEG_LEN - 17'd1;

  state_t      state_q;
  logic [1:0]  seg_q;
  logic [16:0] offset_q;
  logic [7:0]  wait_q;
  logic        load_done_q;
  logic        wr_we_q;
  logic [16:0] wr_addr_q;
  logic [7:0]  wr_data_q;
  logic [16:0] seg_base_s;

  // RAM base address of the image currently being loaded
  always_comb begin
    seg_base_s = 17'h00000;
    case (seg_q)
      2'd0:    seg_base_s = SEG_RAM[16:0];
      2'd1:    seg_base_s = SEG_RAM[33:17];
      2'd2:    seg_base_s = SEG_RAM[50:34];
      2'd3:    seg_base_s = SEG_RAM[67:51];
      default: seg_base_s = 17'h00000;
    endcase
  end

  // Flash address is formed directly from the image/offset counters
  assign flash_addr  = FLASH_BASE + ({22'h0, seg_q} * {7'h0, SEG_LEN}) + {7'h0, offset_q};
  assign flash_valid = (state_q == ST_LOAD);
  assign load_done   = load_done_q;
  assign core_reset  = ~load_done_q;
  assign seg_idx     = seg_q;

  // Load sequencer: counters, one-cycle write strobe, settle wait and handover
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      seg_q       <= 2'd0;
      offset_q    <= 17'd0;
      wait_q      <= 8'd0;
      load_done_q <= 1'b0;
      wr_we_q     <= 1'b0;
      wr_addr_q   <= 17'd0;
      wr_data_q   <= 8'd0;
    end else begin
      wr_we_q <= 1'b0;
      case (state_q)
        ST_LOAD: begin
          if (flash_ready) begin
            wr_we_q   <= 1'b1;
            wr_addr_q <= seg_base_s + offset_q;
            wr_data_q <= flash_rdata;
            if (offset_q == LAST_OFF) begin
              offset_q <= 17'd0;
              if (seg_q == LAST_SEG) begin
                state_q <= ST_LAST;
              end else begin
                seg_q <= seg_q + 2'd1;
              end
            end else begin
              offset_q <= offset_q + 17'd1;
            end
          end
        end
        ST_LAST: begin
          state_q <= ST_SETTLE;
          wait_q  <= 8'd0;
        end
        ST_SETTLE: begin
          if (wait_q == SETTLE) begin
            state_q     <= ST_DONE;
            load_done_q <= 1'b1;
          end else begin
            wait_q <= wait_q + 8'd1;
          end
        end
        ST_DONE: begin
          if (reload) begin
            state_q     <= ST_LOAD;
            load_done_q <= 1'b0;
            seg_q       <= 2'd0;
            offset_q    <= 17'd0;
            wait_q      <= 8'd0;
          end
        end
        default: begin
          state_q <= ST_LOAD;
        end
      endcase
    end
  end

  // RAM port: loader write registers until handover, then core passthrough
  always_comb begin
    ram_addr = wr_addr_q;
    ram_we   = wr_we_q;
    ram_din  = wr_data_q;
    if (load_done_q) begin
      ram_addr = core_addr;
      ram_we   = core_we;
      ram_din  = core_din;
    end else begin
      ram_addr = wr_addr_q;
      ram_we   = wr_we_q;
      ram_din  = wr_data_q;
    end
  end

`ifdef ROM_CHECKSUM_EN
  logic [15:0] checksum_q;
  logic [15:0] checksum_d;

  // Next running sum: add each byte as it is written into RAM
  always_comb begin
    checksum_d = checksum_q;
    if (wr_we_q) begin
      checksum_d = checksum_q + {8'h00, wr_data_q};
    end else begin
      checksum_d = checksum_q;
    end
  end

  // Running sum register, restarted by reset and by an accepted reload
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      checksum_q <= 16'h0000;
    end else if ((state_q == ST_DONE) && reload) begin
      checksum_q <= 16'h0000;
    end else begin
      checksum_q <= checksum_d;
    end
  end

  assign checksum = checksum_q;
`else
  assign checksum = 16'h0000;
`endif

endmodule

// File: tb/tb_rom_load_sequencer.sv
// Self-checking bench for rom_load_sequencer: flash model answering every 4th
// cycle, scoreboard of expected RAM writes, reload/reset/handover scenarios.
module tb_rom_load_sequencer;

  localparam logic [23:0] TB_BASE    = 24'h080000;
  localparam int          TB_NSEG    = 3;
  localparam int          TB_SEGLEN  = 64;
  localparam logic [7:0]  TB_SETTLE  = 8'h07;
  localparam int          TB_TOTAL   = TB_NSEG * TB_SEGLEN;

  logic        clk = 1'b0;
  logic        reset_n, reload, flash_valid, flash_ready;
  logic [23:0] flash_addr;
  logic [7:0]  flash_rdata;
  logic [16:0] core_addr;
  logic        core_we;
  logic [7:0]  core_din;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_din;
  logic        load_done, core_reset;
  logic [1:0]  seg_idx;
  logic [15:0] checksum;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          exp_idx  = 0;
  int          gap      = 0;
  int          final_cyc = 0;
  int          wr_cnt   = 0;
  bit          last_issued = 1'b0;
  logic [15:0] exp_sum  = 16'h0000;
  logic [24:0] exp_q [$];

  rom_load_sequencer #(
    .FLASH_BASE (TB_BASE),
    .NSEG       (TB_NSEG),
    .SEG_LEN    (17'(TB_SEGLEN)),
    .SEG_RAM    ({17'h00000, 17'h14000, 17'h10000, 17'h0C000}),
    .SETTLE     (TB_SETTLE)
  ) dut (
    .clk (clk), .reset_n (reset_n), .reload (reload),
    .flash_valid (flash_valid), .flash_ready (flash_ready),
    .flash_addr (flash_addr), .flash_rdata (flash_rdata),
    .core_addr (core_addr), .core_we (core_we), .core_din (core_din),
    .ram_addr (ram_addr), .ram_we (ram_we), .ram_din (ram_din),
    .load_done (load_done), .core_reset (core_reset),
    .seg_idx (seg_idx), .checksum (checksum)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] tb_seg_base(input int s);
    case (s)
      0:       return 17'h0C000;
      1:       return 17'h10000;
      default: return 17'h14000;
    endcase
  endfunction

  function automatic logic [15:0] tb_exp_checksum();
`ifdef ROM_CHECKSUM_EN
    return exp_sum;
`else
    return 16'h0000;
`endif
  endfunction

  // Flash model: ready strobe every 4th cycle of valid, data = address low byte
  initial begin
    logic [23:0] fa;
    logic [16:0] ra;
    flash_ready = 1'b0;
    flash_rdata = 8'h00;
    forever begin
      @(posedge clk);
      #1;
      if (!reset_n || load_done) begin
        flash_ready = 1'b0;
        exp_idx = 0;
        gap = 0;
        last_issued = 1'b0;
        if (!reset_n) exp_q.delete();
      end else begin
        flash_ready = 1'b0;
        if (last_issued) begin
          check_val("valid_low_after_last", 32'(flash_valid), 32'd0);
          last_issued = 1'b0;
        end
        if (flash_valid && exp_idx < TB_TOTAL) begin
          gap++;
          if (gap == 4) begin
            gap = 0;
            fa = TB_BASE + 24'(exp_idx);
            ra = tb_seg_base(exp_idx / TB_SEGLEN) + 17'(exp_idx % TB_SEGLEN);
            check_val("flash_addr", 32'(flash_addr), 32'(fa));
            check_val("seg_idx_load", 32'(seg_idx), 32'(exp_idx / TB_SEGLEN));
            flash_rdata = fa[7:0];
            flash_ready = 1'b1;
            exp_q.push_back({ra, fa[7:0]});
            exp_idx++;
            if (exp_idx == TB_TOTAL) begin
              last_issued = 1'b1;
              final_cyc = cyc;
            end
          end
        end
      end
    end
  end

  // RAM write monitor: every loader write must match the head of the scoreboard
  always @(negedge clk) begin
    logic [24:0] e;
    if (reset_n && !load_done && ram_we) begin
      if (exp_q.size() == 0) begin
        check_val("extra_write", 32'(ram_addr), 32'h1FFFFFFF);
      end else begin
        e = exp_q.pop_front();
        check_val("ram_addr", 32'(ram_addr), 32'(e[24:8]));
        check_val("ram_din", 32'(ram_din), 32'(e[7:0]));
        wr_cnt++;
        exp_sum = exp_sum + {8'h00, e[7:0]};
      end
    end
  end

  task automatic wait_idx(input int n);
    bit hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(posedge clk);
      #2;
      if (exp_idx >= n) hit = 1'b1;
    end
    check_val("reach_index", 32'(hit), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    bit hit = 1'b0;
    for (int i = 0; i < 4000 && !hit; i++) begin
      @(posedge clk);
      #3;
      if (load_done) hit = 1'b1;
    end
    check_val({tag, "_done_seen"}, 32'(hit), 32'd1);
    if (hit) check_val({tag, "_done_latency"}, 32'(cyc), 32'(final_cyc + 3 + int'(TB_SETTLE)));
  endtask

  task automatic check_load(input string tag);
    check_val({tag, "_writes"}, 32'(wr_cnt), 32'(TB_TOTAL));
    check_val({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check_val({tag, "_seg_idx_hold"}, 32'(seg_idx), 32'(TB_NSEG - 1));
    check_val({tag, "_core_reset"}, 32'(core_reset), 32'd0);
    check_val({tag, "_flash_valid"}, 32'(flash_valid), 32'd0);
    check_val({tag, "_checksum"}, 32'(checksum), 32'(tb_exp_checksum()));
  endtask

  task automatic start_reload(input string tag);
    @(posedge clk);
    #2;
    core_we = 1'b1;
    reload = 1'b1;
    wr_cnt = 0;
    exp_sum = 16'h0000;
    @(posedge clk);
    #2;
    reload = 1'b0;
    check_val({tag, "_done_cleared"}, 32'(load_done), 32'd0);
    check_val({tag, "_addr_restart"}, 32'(flash_addr), 32'(TB_BASE));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    reload    = 1'b0;
    core_addr = 17'h1ABCD;
    core_we   = 1'b1;
    core_din  = 8'hEE;
    repeat (3) @(posedge clk);
    #3;
    check_val("rst_load_done", 32'(load_done), 32'd0);
    check_val("rst_core_reset", 32'(core_reset), 32'd1);
    check_val("rst_ram_we", 32'(ram_we), 32'd0);
    check_val("rst_flash_addr", 32'(flash_addr), 32'(TB_BASE));
    check_val("rst_seg_idx", 32'(seg_idx), 32'd0);
    check_val("rst_checksum", 32'(checksum), 32'd0);
    @(posedge clk);
    #2;
    reset_n = 1'b1;
    wr_cnt = 0;
    exp_sum = 16'h0000;

    // reload during LOAD must be ignored; core writes during load must not reach RAM
    wait_idx(70);
    reload = 1'b1;
    @(posedge clk);
    #2;
    reload = 1'b0;
    check_val("reload_in_load_done", 32'(load_done), 32'd0);
    wait_done("load1");
    check_load("load1");

    // handover: RAM port follows core inputs in the same cycle
    for (int i = 0; i < 4; i++) begin
      core_addr = 17'($urandom);
      core_we   = i[0];
      core_din  = 8'($urandom);
      #1;
      check_val("pass_addr", 32'(ram_addr), 32'(core_addr));
      check_val("pass_we", 32'(ram_we), 32'(core_we));
      check_val("pass_din", 32'(ram_din), 32'(core_din));
    end

    start_reload("reload2");
    wait_done("load2");
    check_load("load2");

    // reset in the middle of image 1 restarts from image 0 byte 0
    start_reload("reload3");
    wait_idx(TB_SEGLEN + 16);
    reset_n = 1'b0;
    wr_cnt = 0;
    exp_sum = 16'h0000;
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #3;
    check_val("rstmid_flash_addr", 32'(flash_addr), 32'(TB_BASE));
    check_val("rstmid_seg_idx", 32'(seg_idx), 32'd0);
    check_val("rstmid_load_done", 32'(load_done), 32'd0);
    check_val("rstmid_checksum", 32'(checksum), 32'd0);
    wait_done("load3");
    check_load("load3");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
